// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage.
package wb_stage_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] LOAD_F3_LB  = 3'b000;
    localparam logic [2:0] LOAD_F3_LH  = 3'b001;
    localparam logic [2:0] LOAD_F3_LW  = 3'b010;
    localparam logic [2:0] LOAD_F3_LBU = 3'b100;
    localparam logic [2:0] LOAD_F3_LHU = 3'b101;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic                  valid;
        logic                  write_en;
        logic                  is_load;
        logic [2:0]            funct3;
        logic [1:0]            addr_lo;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]       result;
    } wb_in;

    typedef struct packed {
        logic                  write_en;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]       rd_data;
    } regfile_in;

endpackage

// File: rtl/wb_stage_load_align.sv
// Selects and sign/zero-extends the addressed byte or halfword of a load word.
module wb_stage_load_align
    import wb_stage_pkg::*;
(
    input  logic [XLEN-1:0] raw_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw_i[8*off_i +: 8];
        // off[0] does not participate in halfword selection
        half_sel = off_i[1] ? raw_i[31:16] : raw_i[15:0];
        data_o   = raw_i;
        case (funct3_i)
            LOAD_F3_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            LOAD_F3_LH:  data_o = {{16{half_sel[15]}}, half_sel};
            LOAD_F3_LW:  data_o = raw_i;
            LOAD_F3_LBU: data_o = {24'd0, byte_sel};
            LOAD_F3_LHU: data_o = {16'd0, half_sel};
            default:     data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register driving the register-file write port.
// state     | meaning
// IDLE      | capturing from MEM (unless stalled); held result may be written
// LOAD_WAIT | load captured, waiting for the dmem response pulse
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  mem_valid_i,
    input  logic                  mem_write_en_i,
    input  logic                  mem_is_load_i,
    input  logic [2:0]            mem_funct3_i,
    input  logic [1:0]            mem_addr_lo_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr_i,
    input  logic [XLEN-1:0]       mem_result_i,
    input  logic                  dmem_rvalid_i,
    input  logic [XLEN-1:0]       dmem_rdata_i,
    output logic                  wb_busy_o,
    output logic                  rf_write_en_o,
    output logic [REG_ADDR_W-1:0] rf_rd_addr_o,
    output logic [XLEN-1:0]       rf_rd_data_o,
    output logic [63:0]           instret_o
);

    wb_state_e             state_q, state_d;
    logic                  valid_q, valid_d;
    logic                  write_en_q, write_en_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic [63:0]           instret_q, instret_d;

    wb_in                  mem_in;
    regfile_in             rf_wr;
    logic [XLEN-1:0]       load_data;

    assign mem_in = '{valid:    mem_valid_i,
                      write_en: mem_write_en_i,
                      is_load:  mem_is_load_i,
                      funct3:   mem_funct3_i,
                      addr_lo:  mem_addr_lo_i,
                      rd_addr:  mem_rd_addr_i,
                      result:   mem_result_i};

    wb_stage_load_align u_align (
        .raw_i    (dmem_rdata_i),
        .funct3_i (funct3_q),
        .off_i    (addr_lo_q),
        .data_o   (load_data)
    );

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        write_en_d = write_en_q;
        funct3_d   = funct3_q;
        addr_lo_d  = addr_lo_q;
        rd_addr_d  = rd_addr_q;
        data_d     = data_q;
        instret_d  = instret_q;

        if (valid_q && (state_q == IDLE) && !stall_i) begin
            instret_d = instret_q + 64'd1;
        end

        if (state_q == IDLE) begin
            if (!stall_i) begin
                valid_d    = mem_in.valid;
                write_en_d = mem_in.write_en;
                funct3_d   = mem_in.funct3;
                addr_lo_d  = mem_in.addr_lo;
                rd_addr_d  = mem_in.rd_addr;
                data_d     = mem_in.result;
                if (mem_in.valid && mem_in.is_load) begin
                    state_d = LOAD_WAIT;
                end
            end
        end else begin
            // memory never resends, so the response is taken regardless of stall
            if (dmem_rvalid_i) begin
                data_d  = load_data;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            write_en_q <= 1'b0;
            funct3_q   <= 3'd0;
            addr_lo_q  <= 2'd0;
            rd_addr_q  <= '0;
            data_q     <= '0;
            instret_q  <= 64'd0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            write_en_q <= write_en_d;
            funct3_q   <= funct3_d;
            addr_lo_q  <= addr_lo_d;
            rd_addr_q  <= rd_addr_d;
            data_q     <= data_d;
            instret_q  <= instret_d;
        end
    end

    assign rf_wr.write_en = valid_q && write_en_q && (state_q == IDLE) && (|rd_addr_q);
    assign rf_wr.rd_addr  = rd_addr_q;
    assign rf_wr.rd_data  = data_q;

    assign wb_busy_o     = (state_q == LOAD_WAIT);
    assign rf_write_en_o = rf_wr.write_en;
    assign rf_rd_addr_o  = rf_wr.rd_addr;
    assign rf_rd_data_o  = rf_wr.rd_data;
    assign instret_o     = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected register-file writes are queued at issue.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        mem_valid_i;
    logic        mem_write_en_i;
    logic        mem_is_load_i;
    logic [2:0]  mem_funct3_i;
    logic [1:0]  mem_addr_lo_i;
    logic [4:0]  mem_rd_addr_i;
    logic [31:0] mem_result_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_busy_o;
    logic        rf_write_en_o;
    logic [4:0]  rf_rd_addr_o;
    logic [31:0] rf_rd_data_o;
    logic [63:0] instret_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [36:0] exp_q[$];
    logic [63:0] base;

    wb_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .mem_valid_i    (mem_valid_i),
        .mem_write_en_i (mem_write_en_i),
        .mem_is_load_i  (mem_is_load_i),
        .mem_funct3_i   (mem_funct3_i),
        .mem_addr_lo_i  (mem_addr_lo_i),
        .mem_rd_addr_i  (mem_rd_addr_i),
        .mem_result_i   (mem_result_i),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .wb_busy_o      (wb_busy_o),
        .rf_write_en_o  (rf_write_en_o),
        .rf_rd_addr_o   (rf_rd_addr_o),
        .rf_rd_data_o   (rf_rd_data_o),
        .instret_o      (instret_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // a write commits on the edge following a negedge where it is visible and unstalled
    always @(negedge clk) begin
        #2;
        if (rst && rf_write_en_o && !stall_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, rf_rd_addr_o, rf_rd_data_o}, 64'd0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(rf_rd_addr_o), 64'(e[36:32]));
                check("wr_data", 64'(rf_rd_data_o), 64'(e[31:0]));
            end
        end
    end

    task automatic drive_idle();
        mem_valid_i    = 1'b0;
        mem_write_en_i = 1'b0;
        mem_is_load_i  = 1'b0;
        mem_funct3_i   = 3'd0;
        mem_addr_lo_i  = 2'd0;
        mem_rd_addr_i  = 5'd0;
        mem_result_i   = 32'd0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic we, input logic [31:0] res);
        mem_valid_i    = 1'b1;
        mem_write_en_i = we;
        mem_is_load_i  = 1'b0;
        mem_funct3_i   = 3'd0;
        mem_addr_lo_i  = 2'd0;
        mem_rd_addr_i  = rd;
        mem_result_i   = res;
        if (we && rd != 5'd0) exp_q.push_back({rd, res});
    endtask

    task automatic load_op(input string tag, input logic [2:0] f3, input logic [1:0] off,
                           input logic [4:0] rd, input logic [31:0] rdata, input int dly,
                           input logic [31:0] exp);
        @(negedge clk);
        mem_valid_i    = 1'b1;
        mem_write_en_i = 1'b1;
        mem_is_load_i  = 1'b1;
        mem_funct3_i   = f3;
        mem_addr_lo_i  = off;
        mem_rd_addr_i  = rd;
        mem_result_i   = 32'hBAD0_BAD0;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            drive_idle();
            check({tag, "_busy"}, 64'(wb_busy_o), 64'd1);
            check({tag, "_nowr"}, 64'(rf_write_en_o), 64'd0);
        end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
        exp_q.push_back({rd, exp});
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'hA5A5_A5A5;
        check({tag, "_idle"}, 64'(wb_busy_o), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        stall_i       = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'd0;
        drive_idle();
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(wb_busy_o), 64'd0);
        check("rst_wen", 64'(rf_write_en_o), 64'd0);
        check("rst_addr", 64'(rf_rd_addr_o), 64'd0);
        check("rst_data", 64'(rf_rd_data_o), 64'd0);
        check("rst_instret", instret_o, 64'd0);
        rst = 1'b1;

        // ALU op to x5
        @(negedge clk);
        drive_alu(5'd5, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        drive_idle();
        check("alu_wen", 64'(rf_write_en_o), 64'd1);
        check("alu_instret_pre", instret_o, 64'd0);
        @(negedge clk);
        check("alu_instret", instret_o, 64'd1);
        check("alu_wen_clr", 64'(rf_write_en_o), 64'd0);

        // write to x0 suppressed, still retires
        drive_alu(5'd0, 1'b1, 32'h1234_5678);
        @(negedge clk);
        drive_idle();
        check("x0_wen", 64'(rf_write_en_o), 64'd0);
        @(negedge clk);
        check("x0_instret", instret_o, 64'd2);

        // back-to-back ALU ops including a non-writing one
        drive_alu(5'd9, 1'b1, 32'h0000_0001);
        @(negedge clk);
        drive_alu(5'd10, 1'b0, 32'hFFFF_FFFF);
        @(negedge clk);
        drive_alu(5'd31, 1'b1, 32'h8000_0000);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        check("b2b_instret", instret_o, 64'd5);

        // loads
        load_op("lb",  3'b000, 2'd2, 5'd3, 32'h12F4_5678, 3, 32'hFFFF_FFF4);
        load_op("lbu", 3'b100, 2'd2, 5'd4, 32'h12F4_5678, 3, 32'h0000_00F4);
        load_op("lhu", 3'b101, 2'd2, 5'd6, 32'h12F4_5678, 1, 32'h0000_12F4);
        load_op("lh",  3'b001, 2'd0, 5'd7, 32'h12F4_5678, 2, 32'h0000_5678);
        load_op("lhs", 3'b001, 2'd3, 5'd8, 32'h8001_0000, 1, 32'hFFFF_8001);
        load_op("lb3", 3'b000, 2'd3, 5'd11, 32'h7F00_0000, 1, 32'h0000_007F);
        load_op("lw",  3'b010, 2'd1, 5'd12, 32'hCAFE_F00D, 4, 32'hCAFE_F00D);
        load_op("f3x", 3'b011, 2'd2, 5'd13, 32'h0BAD_C0DE, 1, 32'h0BAD_C0DE);
        check("load_instret", instret_o, 64'd13);

        // stray response while idle
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        check("stray_busy", 64'(wb_busy_o), 64'd0);
        @(negedge clk);

        // stall with a held write
        drive_alu(5'd14, 1'b1, 32'h0BAD_F00D);
        @(negedge clk);
        drive_idle();
        stall_i = 1'b1;
        base = instret_o;
        repeat (4) begin
            @(negedge clk);
            check("stall_wen", 64'(rf_write_en_o), 64'd1);
            check("stall_addr", 64'(rf_rd_addr_o), 64'd14);
            check("stall_data", 64'(rf_rd_data_o), 64'h0BAD_F00D);
            check("stall_instret", instret_o, base);
        end
        stall_i = 1'b0;
        @(negedge clk);
        check("unstall_instret", instret_o, base + 64'd1);
        check("unstall_wen", 64'(rf_write_en_o), 64'd0);

        // reset while waiting on a load; late response must be dropped
        @(negedge clk);
        mem_valid_i    = 1'b1;
        mem_write_en_i = 1'b1;
        mem_is_load_i  = 1'b1;
        mem_funct3_i   = 3'b010;
        mem_rd_addr_i  = 5'd15;
        @(negedge clk);
        drive_idle();
        check("rl_busy", 64'(wb_busy_o), 64'd1);
        rst = 1'b0;
        #1;
        check("rl_busy0", 64'(wb_busy_o), 64'd0);
        check("rl_wen", 64'(rf_write_en_o), 64'd0);
        check("rl_addr", 64'(rf_rd_addr_o), 64'd0);
        check("rl_data", 64'(rf_rd_data_o), 64'd0);
        check("rl_instret", instret_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h5555_AAAA;
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        check("rl_post_busy", 64'(wb_busy_o), 64'd0);
        @(negedge clk);
        check("rl_post_wen", 64'(rf_write_en_o), 64'd0);
        check("rl_post_instret", instret_o, 64'd0);

        // instret wrap
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        @(negedge clk);
        drive_alu(5'd0, 1'b1, 32'd1);
        @(negedge clk);
        drive_alu(5'd0, 1'b0, 32'd2);
        @(negedge clk);
        drive_idle();
        check("wrap_zero", instret_o, 64'd0);
        @(negedge clk);
        check("wrap_one", instret_o, 64'd1);

        repeat (2) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
